// File: rtl/binary_search_ctrl_pkg.sv
// Shared encodings for the binary-search controller and the magnitude comparators it drives.
package binary_search_ctrl_pkg;

    localparam int REL_GT = 2;
    localparam int REL_EQ = 1;
    localparam int REL_LT = 0;

    localparam logic [2:0] REL_CODE_GT = 3'b100;
    localparam logic [2:0] REL_CODE_EQ = 3'b010;
    localparam logic [2:0] REL_CODE_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    function automatic logic rel_one_hot(input logic [2:0] rel);
        return (rel == REL_CODE_GT) || (rel == REL_CODE_EQ) || (rel == REL_CODE_LT);
    endfunction

endpackage

// File: rtl/binary_search_ctrl.sv
// Binary-search probe controller: issues guesses to an external comparator and narrows
// [lo, hi] from its one-hot relation answers until it sees equal or detects inconsistency.
module binary_search_ctrl
    import binary_search_ctrl_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int STEPW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rel_valid,
    input  logic [2:0]       rel_in,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] found,
    output logic [STEPW-1:0] steps,
    output logic             error
);

    localparam logic [WIDTH-1:0] GMAX  = '1;
    localparam logic [WIDTH-1:0] GINIT = GMAX >> 1;

    state_t           state;
    logic [WIDTH:0]   lo, hi;

    // Bounds math runs one bit wider so guess+1 at the top of range cannot wrap.
    logic [WIDTH:0]   g_ext, lo_up, hi_dn, mid_lt, mid_gt;
    logic [STEPW-1:0] steps_nxt;
    logic             lt_ok, gt_ok;

    always_comb begin
        g_ext     = {1'b0, guess};
        lo_up     = g_ext + 1'b1;
        hi_dn     = g_ext - 1'b1;
        mid_lt    = (lo_up + hi) >> 1;
        mid_gt    = (lo + hi_dn) >> 1;
        lt_ok     = (guess != GMAX) && (lo_up <= hi);
        gt_ok     = (guess != '0) && (lo <= hi_dn);
        steps_nxt = (&steps) ? steps : steps + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lo          <= '0;
            hi          <= '0;
            guess       <= '0;
            guess_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= '0;
            steps       <= '0;
            error       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state       <= PROBE;
                        lo          <= '0;
                        hi          <= {1'b0, GMAX};
                        guess       <= GINIT;
                        guess_valid <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        found       <= '0;
                        steps       <= '0;
                        error       <= 1'b0;
                    end
                end
                PROBE: begin
                    // start is deliberately ignored here; only the relation matters.
                    if (rel_valid) begin
                        steps <= steps_nxt;
                        if (rel_one_hot(rel_in) && rel_in == REL_CODE_EQ) begin
                            state       <= DONE;
                            found       <= guess;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            guess_valid <= 1'b0;
                        end else if (rel_in == REL_CODE_LT && lt_ok) begin
                            lo    <= lo_up;
                            guess <= mid_lt[WIDTH-1:0];
                        end else if (rel_in == REL_CODE_GT && gt_ok) begin
                            hi    <= hi_dn;
                            guess <= mid_gt[WIDTH-1:0];
                        end else begin
                            state       <= ERR;
                            error       <= 1'b1;
                            busy        <= 1'b0;
                            guess_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Directed bench for binary_search_ctrl: comparator responder, spec-level model checked
// every cycle, plus literal guess sequences and end results per search.
module tb_binary_search_ctrl;
    import binary_search_ctrl_pkg::*;

    localparam int W    = 3;
    localparam int SW   = 3;
    localparam int GMAX = 7;
    localparam int SMAX = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rel_valid;
    logic [2:0]    rel_in;
    logic [W-1:0]  guess;
    logic          guess_valid;
    logic          busy;
    logic          done;
    logic [W-1:0]  found;
    logic [SW-1:0] steps;
    logic          error;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    binary_search_ctrl #(.WIDTH(W), .STEPW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rel_valid(rel_valid), .rel_in(rel_in),
        .guess(guess), .guess_valid(guess_valid), .busy(busy), .done(done),
        .found(found), .steps(steps), .error(error)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // comparator_model: mode 0 truthful, 1 always greater, 2 forced 011, 3 scripted answers
    int         secret = 0;
    int         stall_n = 0;
    int         mode = 0;
    int         stall_cnt = 0;
    int         nacc = 0;
    int         base = 0;
    logic [2:0] script [4];
    logic [W-1:0] acc [$];

    always_comb begin
        rel_in = REL_CODE_LT;
        case (mode)
            0: begin
                if (int'(guess) > secret)       rel_in = REL_CODE_GT;
                else if (int'(guess) == secret) rel_in = REL_CODE_EQ;
                else                            rel_in = REL_CODE_LT;
            end
            1: rel_in = REL_CODE_GT;
            2: rel_in = 3'b011;
            3: rel_in = script[2'(nacc - base)];
            default: rel_in = REL_CODE_LT;
        endcase
    end

    always @(negedge clk) begin
        if (guess_valid && stall_cnt < stall_n) begin
            rel_valid = 1'b0;
            stall_cnt++;
        end else if (guess_valid) begin
            rel_valid = 1'b1;
            stall_cnt = 0;
        end else begin
            rel_valid = (stall_n == 0);
            stall_cnt = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && guess_valid && rel_valid) begin
            acc.push_back(guess);
            nacc <= nacc + 1;
        end
    end

    // Spec model: phase 0 idle, 1 probing, 2 found, 3 error; the guess is the midpoint of [lo, hi].
    int m_st, m_lo, m_hi, m_steps, m_found;
    int m_mid;
    assign m_mid = (m_lo + m_hi) / 2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_lo <= 0; m_hi <= 0; m_steps <= 0; m_found <= 0;
        end else if (m_st != 1) begin
            if (start) begin
                m_st <= 1; m_lo <= 0; m_hi <= GMAX; m_steps <= 0; m_found <= 0;
            end
        end else if (rel_valid) begin
            m_steps <= (m_steps < SMAX) ? m_steps + 1 : SMAX;
            if (rel_in == 3'b010) begin
                m_st <= 2; m_found <= m_mid;
            end else if (rel_in == 3'b001) begin
                if (m_mid == GMAX || m_mid + 1 > m_hi) m_st <= 3;
                else m_lo <= m_mid + 1;
            end else if (rel_in == 3'b100) begin
                if (m_mid == 0 || m_lo > m_mid - 1) m_st <= 3;
                else m_hi <= m_mid - 1;
            end else begin
                m_st <= 3;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("guess_valid", int'(guess_valid), int'(m_st == 1));
            chk("busy", int'(busy), int'(m_st == 1));
            chk("done", int'(done), int'(m_st == 2));
            chk("error", int'(error), int'(m_st == 3));
            chk("steps", int'(steps), m_steps);
            chk("found", int'(found), m_found);
            if (m_st == 1) chk("guess", int'(guess), m_mid);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_guess"}, int'(guess), 0);
        chk({tag, "_guess_valid"}, int'(guess_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_found"}, int'(found), 0);
        chk({tag, "_steps"}, int'(steps), 0);
        chk({tag, "_error"}, int'(error), 0);
    endtask

    task automatic run(input int sec, input int st, input int md, input int eg[4], input int n,
                       input bit exp_done, input int exp_found, input int exp_steps,
                       input bit poke);
        int cyc;
        secret = sec; stall_n = st; mode = md;
        @(negedge clk);
        base = nacc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_clear", int'(done | error), 0);
        chk("first_guess", int'(guess), 3);
        cyc = 0;
        while (!(done || error) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = (poke && (cyc == 3 || cyc == 5));
        end
        start = 1'b0;
        chk("search_end", int'(done | error), 1);
        chk("n_probes", nacc - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < acc.size()) chk("probe_guess", int'(acc[base + i]), eg[i]);
            else chk("probe_missing", 0, 1);
        end
        chk("end_done", int'(done), int'(exp_done));
        chk("end_error", int'(error), int'(!exp_done));
        chk("end_found", int'(found), exp_found);
        chk("end_steps", int'(steps), exp_steps);
        chk("end_guess_valid", int'(guess_valid), 0);
        chk("end_busy", int'(busy), 0);
    endtask

    initial begin
        int cyc;
        script[0] = REL_CODE_GT; script[1] = REL_CODE_LT;
        script[2] = REL_CODE_LT; script[3] = REL_CODE_LT;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        run(5, 0, 0, '{3, 5, 0, 0}, 2, 1'b1, 5, 2, 1'b0);
        run(7, 0, 0, '{3, 5, 6, 7}, 4, 1'b1, 7, 4, 1'b0);
        run(0, 0, 0, '{3, 1, 0, 0}, 3, 1'b1, 0, 3, 1'b0);
        run(4, 2, 0, '{3, 5, 4, 0}, 3, 1'b1, 4, 3, 1'b1);
        run(4, 0, 2, '{3, 0, 0, 0}, 1, 1'b0, 0, 1, 1'b0);
        run(6, 0, 0, '{3, 5, 6, 0}, 3, 1'b1, 6, 3, 1'b0);
        run(4, 0, 1, '{3, 1, 0, 0}, 3, 1'b0, 0, 3, 1'b0);
        run(8, 0, 0, '{3, 5, 6, 7}, 4, 1'b0, 0, 4, 1'b0);
        run(0, 1, 3, '{3, 1, 2, 0}, 3, 1'b0, 0, 3, 1'b1);

        // Reset in the middle of a search must clear outputs without waiting for an edge.
        secret = 7; stall_n = 0; mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (steps != 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("midsearch_steps", int'(steps), 2);
        chk("midsearch_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        run(7, 0, 0, '{3, 5, 6, 7}, 4, 1'b1, 7, 4, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
